// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer
// Sequences the DDS DAC engine. An accepted command first loads a full
// waveform table into the engine, one point per write pulse. The points are
// generated internally (saw, triangle, square) or taken from an upstream
// stream. Once the engine reports the table ready, the sequencer enables
// output and steps the frequency through an optional sweep until stopped.
//
// Ports
//   clk, rst_n             clock; synchronous active-high reset (rst_n=1 resets)
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_wave_sel           0 saw, 1 triangle, 2 square, 3 stream
//   cmd_freq_start/step/stop, cmd_dwell, cmd_amplitude   command fields
//   cmd_stop               abort a load or stop output
//   s_valid/s_data/s_ready upstream sample stream (wave_sel 3)
//   dds_enable, frequency, amplitude, wave_wr_pulse, wave_data   to engine
//   waveform_ready         engine table-loaded indication
//   busy, sweep_done, load_error   status
module dac_wave_sequencer #(
  parameter int WAVE_POINTS = 256,
  parameter int PULSE_GAP   = 1,
  parameter int ARM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_wave_sel,
  input  logic [31:0] cmd_freq_start,
  input  logic [31:0] cmd_freq_step,
  input  logic [31:0] cmd_freq_stop,
  input  logic [15:0] cmd_dwell,
  input  logic [7:0]  cmd_amplitude,
  input  logic        cmd_stop,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        dds_enable,
  output logic [31:0] frequency,
  output logic [7:0]  amplitude,
  output logic        wave_wr_pulse,
  output logic [7:0]  wave_data,
  input  logic        waveform_ready,
  output logic        busy,
  output logic        sweep_done,
  output logic        load_error
);

  localparam int IDX_W = (WAVE_POINTS > 1) ? $clog2(WAVE_POINTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WAVE_POINTS - 1);
  localparam logic [15:0] GAP_LAST = 16'(PULSE_GAP - 1);
  localparam logic [15:0] ARM_LAST = 16'(ARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_DATA,
    LD_PULSE,
    LD_GAP,
    ARM,
    RUN
  } state_t;

  state_t state, state_next;

  logic [1:0]       wave_sel_q;
  logic [31:0]      freq_start_q;
  logic [31:0]      freq_step_q;
  logic [31:0]      freq_stop_q;
  logic [15:0]      dwell_q;
  logic [IDX_W-1:0] index;
  logic [15:0]      gap_cnt;
  logic [15:0]      arm_cnt;
  logic [15:0]      dwell_cnt;
  logic [7:0]       idx8;
  logic [7:0]       gen_data;
  logic [32:0]      sweep_sum;
  logic             is_stream;
  logic             gap_done;
  logic             arm_expired;

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign wave_wr_pulse = (state == LD_PULSE);
  assign is_stream     = (wave_sel_q == 2'd3);
  assign s_ready       = (state == LD_DATA) && is_stream;
  assign gap_done      = (gap_cnt == GAP_LAST);
  assign arm_expired   = (arm_cnt == ARM_LAST);
  assign idx8          = 8'(index);
  // One extra bit so a sum that passes 2^32 still compares above the stop bound.
  assign sweep_sum     = {1'b0, frequency} + {1'b0, freq_step_q};

  // Built-in waveforms. For the descending half of the triangle,
  // 2*(255-i) equals ~i shifted left by one, which avoids a subtractor.
  always_comb begin
    gen_data = idx8;
    case (wave_sel_q)
      2'd1:    gen_data = idx8[7] ? {~idx8[6:0], 1'b0} : {idx8[6:0], 1'b0};
      2'd2:    gen_data = idx8[7] ? 8'h00 : 8'hFF;
      default: gen_data = idx8;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A stop outside IDLE overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cmd_valid) state_next = LD_DATA;
      LD_DATA:  if (!is_stream || s_valid) state_next = LD_PULSE;
      LD_PULSE: state_next = LD_GAP;
      LD_GAP:   if (gap_done) state_next = (index == IDX_LAST) ? ARM : LD_DATA;
      ARM: begin
        if (waveform_ready)   state_next = RUN;
        else if (arm_expired) state_next = IDLE;
      end
      RUN:      state_next = RUN;
      default:  state_next = IDLE;
    endcase
    if (cmd_stop && state != IDLE) state_next = IDLE;
  end

  // Datapath. On a stop the engine outputs keep their values; only the
  // enable drops and the point index rewinds for the next command.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wave_sel_q   <= 2'd0;
      freq_start_q <= 32'd0;
      freq_step_q  <= 32'd0;
      freq_stop_q  <= 32'd0;
      dwell_q      <= 16'd0;
      index        <= '0;
      gap_cnt      <= 16'd0;
      arm_cnt      <= 16'd0;
      dwell_cnt    <= 16'd0;
      dds_enable   <= 1'b0;
      frequency    <= 32'd0;
      amplitude    <= 8'd0;
      wave_data    <= 8'd0;
      sweep_done   <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (cmd_stop && state != IDLE) begin
        index      <= '0;
        gap_cnt    <= 16'd0;
        arm_cnt    <= 16'd0;
        dds_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              wave_sel_q   <= cmd_wave_sel;
              freq_start_q <= cmd_freq_start;
              freq_step_q  <= cmd_freq_step;
              freq_stop_q  <= cmd_freq_stop;
              dwell_q      <= (cmd_dwell == 16'd0) ? 16'd1 : cmd_dwell;
              amplitude    <= cmd_amplitude;
              index        <= '0;
              gap_cnt      <= 16'd0;
              arm_cnt      <= 16'd0;
              load_error   <= 1'b0;
              dds_enable   <= 1'b0;
            end
          end
          LD_DATA: begin
            gap_cnt <= 16'd0;
            if (!is_stream)   wave_data <= gen_data;
            else if (s_valid) wave_data <= s_data;
          end
          LD_PULSE: gap_cnt <= 16'd0;
          LD_GAP: begin
            if (gap_done) begin
              index   <= index + IDX_W'(1);
              arm_cnt <= 16'd0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          ARM: begin
            if (waveform_ready) begin
              frequency  <= freq_start_q;
              dds_enable <= 1'b1;
              dwell_cnt  <= dwell_q;
            end else if (arm_expired) begin
              load_error <= 1'b1;
            end else begin
              arm_cnt <= arm_cnt + 16'd1;
            end
          end
          RUN: begin
            // A count of one marks the last cycle of the current dwell.
            if (dwell_cnt <= 16'd1) begin
              dwell_cnt <= dwell_q;
              if (freq_step_q != 32'd0) begin
                if (sweep_sum <= {1'b0, freq_stop_q}) begin
                  frequency <= sweep_sum[31:0];
                end else begin
                  frequency  <= freq_start_q;
                  sweep_done <= 1'b1;
                end
              end
            end else begin
              dwell_cnt <= dwell_cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// tb_dac_wave_sequencer
// Self-checking bench for dac_wave_sequencer. Expected write data and
// frequency/sweep_done sequences are queued when a command is issued and
// popped as the design produces write pulses or run-state samples.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dac_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_wave_sel;
  logic [31:0] cmd_freq_start;
  logic [31:0] cmd_freq_step;
  logic [31:0] cmd_freq_stop;
  logic [15:0] cmd_dwell;
  logic [7:0]  cmd_amplitude;
  logic        cmd_stop;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        dds_enable;
  logic [31:0] frequency;
  logic [7:0]  amplitude;
  logic        wave_wr_pulse;
  logic [7:0]  wave_data;
  logic        waveform_ready;
  logic        busy;
  logic        sweep_done;
  logic        load_error;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  logic [31:0] freq_q[$];
  logic        done_q[$];

  int cap_pulses;
  int cap_gap_err;
  int cap_last_cycle;
  bit cap_en_seen;
  bit cap_sready_err;

  always #5 clk = ~clk;

  dac_wave_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_wave_sel   (cmd_wave_sel),
    .cmd_freq_start (cmd_freq_start),
    .cmd_freq_step  (cmd_freq_step),
    .cmd_freq_stop  (cmd_freq_stop),
    .cmd_dwell      (cmd_dwell),
    .cmd_amplitude  (cmd_amplitude),
    .cmd_stop       (cmd_stop),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .dds_enable     (dds_enable),
    .frequency      (frequency),
    .amplitude      (amplitude),
    .wave_wr_pulse  (wave_wr_pulse),
    .wave_data      (wave_data),
    .waveform_ready (waveform_ready),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .load_error     (load_error)
  );

  // Issue one command; returns on the falling edge just after acceptance.
  task automatic send_cmd(input logic [1:0] sel, input logic [31:0] start,
                          input logic [31:0] step, input logic [31:0] stop,
                          input logic [15:0] dwell, input logic [7:0] amp);
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_wave_sel   = sel;
    cmd_freq_start = start;
    cmd_freq_step  = step;
    cmd_freq_stop  = stop;
    cmd_dwell      = dwell;
    cmd_amplitude  = amp;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Hold cmd_stop for one edge; returns on the following falling edge.
  task automatic pulse_stop();
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
  endtask

  // Record write-pulse data and load-time observations (no judging here).
  task automatic capture_load(input int want, input int budget);
    bit prev;
    int cyc;
    cap_q.delete();
    cap_pulses = 0; cap_gap_err = 0; cap_last_cycle = 0;
    cap_en_seen = 1'b0; cap_sready_err = 1'b0;
    prev = 1'b0; cyc = 0;
    while (cap_pulses < want && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (dds_enable) cap_en_seen = 1'b1;
      if (s_ready && (wave_wr_pulse || prev)) cap_sready_err = 1'b1;
      if (wave_wr_pulse) begin
        if (prev) cap_gap_err++;
        cap_q.push_back(wave_data);
        cap_pulses++;
        cap_last_cycle = cyc;
      end
      prev = wave_wr_pulse;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
    check_cnt++; if (dds_enable !== 1'b0) $display("[TB] FAIL reset_dds_enable: got %0b expected 0", dds_enable); else pass_cnt++;
    check_cnt++; if (frequency !== 32'd0) $display("[TB] FAIL reset_frequency: got %0h expected 0", frequency); else pass_cnt++;
    check_cnt++; if (amplitude !== 8'd0) $display("[TB] FAIL reset_amplitude: got %0h expected 0", amplitude); else pass_cnt++;
    check_cnt++; if (wave_wr_pulse !== 1'b0) $display("[TB] FAIL reset_pulse: got %0b expected 0", wave_wr_pulse); else pass_cnt++;
    check_cnt++; if (wave_data !== 8'd0) $display("[TB] FAIL reset_wave_data: got %0h expected 0", wave_data); else pass_cnt++;
    check_cnt++; if (s_ready !== 1'b0) $display("[TB] FAIL reset_s_ready: got %0b expected 0", s_ready); else pass_cnt++;
    check_cnt++; if (load_error !== 1'b0 || sweep_done !== 1'b0) $display("[TB] FAIL reset_flags: got err=%0b done=%0b expected 0 0", load_error, sweep_done); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    check_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL idle_cmd_ready: got %0b expected 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_saw();
    int  n;
    bit  found;
    logic [7:0] e, a;
    $display("[TB] saw load");
    waveform_ready = 1'b0;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    send_cmd(2'd0, 32'h0100_0000, 32'd0, 32'h0200_0000, 16'd4, 8'h80);
    check_cnt++; if (amplitude !== 8'h80) $display("[TB] FAIL saw_amp_at_accept: got %0h expected 80", amplitude); else pass_cnt++;
    check_cnt++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL saw_busy: got ready=%0b busy=%0b expected 0 1", cmd_ready, busy); else pass_cnt++;
    capture_load(256, 1000);
    check_cnt++; if (cap_pulses !== 256) $display("[TB] FAIL saw_pulses: got %0d expected 256", cap_pulses); else pass_cnt++;
    check_cnt++; if (cap_gap_err !== 0) $display("[TB] FAIL saw_gap: got %0d back-to-back pulses expected 0", cap_gap_err); else pass_cnt++;
    check_cnt++; if (cap_en_seen !== 1'b0) $display("[TB] FAIL saw_enable_in_load: got 1 expected 0"); else pass_cnt++;
    check_cnt++; if (cap_last_cycle !== 766) $display("[TB] FAIL saw_load_time: got %0d expected 766", cap_last_cycle); else pass_cnt++;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_cnt++;
      if (cap_q.size() == 0) $display("[TB] FAIL saw_data[%0d]: got none expected %0h", n, e);
      else begin
        a = cap_q.pop_front();
        if (a !== e) $display("[TB] FAIL saw_data[%0d]: got %0h expected %0h", n, a, e); else pass_cnt++;
      end
      n++;
    end
    waveform_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (dds_enable === 1'b1) found = 1'b1;
    end
    check_cnt++; if (!found) $display("[TB] FAIL saw_enable_timeout: got dds_enable=0 expected 1"); else pass_cnt++;
    check_cnt++; if (frequency !== 32'h0100_0000) $display("[TB] FAIL saw_frequency: got %0h expected 1000000", frequency); else pass_cnt++;
    check_cnt++; if (amplitude !== 8'h80) $display("[TB] FAIL saw_amplitude: got %0h expected 80", amplitude); else pass_cnt++;
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (sweep_done) found = 1'b1;
    end
    check_cnt++; if (frequency !== 32'h0100_0000 || found) $display("[TB] FAIL saw_fixed_tone: got %0h done=%0b expected 1000000 done=0", frequency, found); else pass_cnt++;
    pulse_stop();
    check_cnt++; if (busy !== 1'b0 || dds_enable !== 1'b0) $display("[TB] FAIL saw_stop: got busy=%0b en=%0b expected 0 0", busy, dds_enable); else pass_cnt++;
    check_cnt++; if (frequency !== 32'h0100_0000 || amplitude !== 8'h80) $display("[TB] FAIL saw_stop_hold: got %0h/%0h expected 1000000/80", frequency, amplitude); else pass_cnt++;
    waveform_ready = 1'b0;
  endtask

  task automatic test_gen_modes();
    int n;
    logic [7:0] e, a;
    for (int m = 1; m <= 2; m++) begin
      $display("[TB] generated mode %0d", m);
      for (int i = 0; i < 256; i++) begin
        if (m == 1) exp_q.push_back(8'((i < 128) ? 2 * i : 2 * (255 - i)));
        else        exp_q.push_back((i < 128) ? 8'hFF : 8'h00);
      end
      send_cmd(2'(m), 32'd5, 32'd0, 32'd5, 16'd1, 8'h40);
      capture_load(256, 1000);
      check_cnt++; if (cap_pulses !== 256) $display("[TB] FAIL gen%0d_pulses: got %0d expected 256", m, cap_pulses); else pass_cnt++;
      n = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_cnt++;
        if (cap_q.size() == 0) $display("[TB] FAIL gen%0d_data[%0d]: got none expected %0h", m, n, e);
        else begin
          a = cap_q.pop_front();
          if (a !== e) $display("[TB] FAIL gen%0d_data[%0d]: got %0h expected %0h", m, n, a, e); else pass_cnt++;
        end
        n++;
      end
      pulse_stop();
      check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL gen%0d_stop: got busy=%0b expected 0", m, busy); else pass_cnt++;
    end
  endtask

  task automatic test_stream();
    int n, k, dcyc;
    bit tog;
    logic [7:0] e, a;
    $display("[TB] stream load");
    for (int i = 0; i < 256; i++) exp_q.push_back(8'hA5 ^ 8'(i));
    send_cmd(2'd3, 32'd7, 32'd0, 32'd7, 16'd1, 8'h33);
    fork
      capture_load(256, 3000);
      begin
        k = 0; tog = 1'b0; dcyc = 0;
        while (k < 256 && dcyc < 3000) begin
          @(negedge clk);
          dcyc++;
          s_valid = tog;
          s_data  = 8'hA5 ^ 8'(k);
          #1;
          if (s_valid && s_ready) k++;
          tog = ~tog;
        end
        @(negedge clk);
        s_valid = 1'b0;
      end
    join
    check_cnt++; if (cap_pulses !== 256) $display("[TB] FAIL stream_pulses: got %0d expected 256", cap_pulses); else pass_cnt++;
    check_cnt++; if (cap_sready_err !== 1'b0) $display("[TB] FAIL stream_s_ready: got high outside load-data expected low"); else pass_cnt++;
    check_cnt++; if (cap_en_seen !== 1'b0) $display("[TB] FAIL stream_enable_in_load: got 1 expected 0"); else pass_cnt++;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_cnt++;
      if (cap_q.size() == 0) $display("[TB] FAIL stream_data[%0d]: got none expected %0h", n, e);
      else begin
        a = cap_q.pop_front();
        if (a !== e) $display("[TB] FAIL stream_data[%0d]: got %0h expected %0h", n, a, e); else pass_cnt++;
      end
      n++;
    end
    pulse_stop();
    check_cnt++; if (busy !== 1'b0 || s_ready !== 1'b0) $display("[TB] FAIL stream_stop: got busy=%0b s_ready=%0b expected 0 0", busy, s_ready); else pass_cnt++;
  endtask

  task automatic test_sweep();
    int unsigned cs[3] = '{100, 300, 10};
    int unsigned cp[3] = '{50, 50, 5};
    int unsigned ce[3] = '{200, 200, 20};
    int unsigned cd[3] = '{4, 4, 0};
    longint f;
    int de;
    bit dn, found;
    logic [31:0] ef;
    logic ed;
    waveform_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      $display("[TB] sweep config %0d", c);
      f = longint'(cs[c]); dn = 1'b0;
      de = (cd[c] == 0) ? 1 : int'(cd[c]);
      for (int n = 0; n < 24; n++) begin
        freq_q.push_back(f[31:0]);
        done_q.push_back(dn);
        dn = 1'b0;
        if ((n + 1) % de == 0 && cp[c] != 0) begin
          if (f + longint'(cp[c]) > longint'(ce[c])) begin
            f = longint'(cs[c]);
            dn = 1'b1;
          end else begin
            f = f + longint'(cp[c]);
          end
        end
      end
      send_cmd(2'd0, cs[c], cp[c], ce[c], 16'(cd[c]), 8'h11);
      capture_load(256, 1000);
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(negedge clk);
        if (dds_enable === 1'b1) found = 1'b1;
      end
      check_cnt++; if (!found) $display("[TB] FAIL sweep%0d_enable_timeout: got dds_enable=0 expected 1", c); else pass_cnt++;
      if (!found) begin
        freq_q.delete();
        done_q.delete();
      end
      for (int n = 0; freq_q.size() > 0; n++) begin
        if (n > 0) @(negedge clk);
        ef = freq_q.pop_front();
        ed = done_q.pop_front();
        check_cnt++; if (frequency !== ef) $display("[TB] FAIL sweep%0d_freq[%0d]: got %0d expected %0d", c, n, frequency, ef); else pass_cnt++;
        check_cnt++; if (sweep_done !== ed) $display("[TB] FAIL sweep%0d_done[%0d]: got %0b expected %0b", c, n, sweep_done, ed); else pass_cnt++;
      end
      cmd_valid = 1'b1;
      cmd_amplitude = 8'h99;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_cnt++; if (amplitude !== 8'h11 || busy !== 1'b1) $display("[TB] FAIL sweep%0d_cmd_ignored: got amp=%0h busy=%0b expected 11 1", c, amplitude, busy); else pass_cnt++;
      pulse_stop();
      check_cnt++; if (busy !== 1'b0 || dds_enable !== 1'b0) $display("[TB] FAIL sweep%0d_stop: got busy=%0b en=%0b expected 0 0", c, busy, dds_enable); else pass_cnt++;
    end
    waveform_ready = 1'b0;
  endtask

  task automatic test_stop_mid_load();
    int extra;
    logic [7:0] e, a;
    $display("[TB] stop mid load");
    waveform_ready = 1'b0;
    send_cmd(2'd0, 32'd1, 32'd0, 32'd1, 16'd1, 8'h22);
    capture_load(38, 200);
    check_cnt++; if (cap_pulses !== 38 || cap_q[37] !== 8'd37) $display("[TB] FAIL stop_point37: got pulses=%0d data=%0h expected 38 25", cap_pulses, cap_q[cap_q.size()-1]); else pass_cnt++;
    pulse_stop();
    check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || wave_wr_pulse !== 1'b0) $display("[TB] FAIL stop_idle: got busy=%0b ready=%0b pulse=%0b expected 0 1 0", busy, cmd_ready, wave_wr_pulse); else pass_cnt++;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wave_wr_pulse) extra++;
    end
    check_cnt++; if (extra !== 0) $display("[TB] FAIL stop_no_pulses: got %0d expected 0", extra); else pass_cnt++;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    send_cmd(2'd0, 32'd1, 32'd0, 32'd1, 16'd1, 8'h22);
    capture_load(4, 50);
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      check_cnt++;
      if (cap_q.size() == 0) $display("[TB] FAIL restart_data[%0d]: got none expected %0h", n, e);
      else begin
        a = cap_q.pop_front();
        if (a !== e) $display("[TB] FAIL restart_data[%0d]: got %0h expected %0h", n, a, e); else pass_cnt++;
      end
    end
    pulse_stop();
  endtask

  task automatic test_arm_timeout();
    int n;
    bit en;
    $display("[TB] arm timeout");
    waveform_ready = 1'b0;
    send_cmd(2'd0, 32'd9, 32'd0, 32'd9, 16'd1, 8'h44);
    capture_load(256, 1000);
    check_cnt++; if (cap_pulses !== 256) $display("[TB] FAIL arm_pulses: got %0d expected 256", cap_pulses); else pass_cnt++;
    n = 0; en = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (dds_enable) en = 1'b1;
    end
    check_cnt++; if (n !== 17) $display("[TB] FAIL arm_timeout_cycles: got %0d expected 17", n); else pass_cnt++;
    check_cnt++; if (load_error !== 1'b1) $display("[TB] FAIL arm_load_error: got %0b expected 1", load_error); else pass_cnt++;
    check_cnt++; if (en !== 1'b0 || dds_enable !== 1'b0) $display("[TB] FAIL arm_enable: got %0b expected 0", en); else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++; if (load_error !== 1'b1) $display("[TB] FAIL arm_error_sticky: got %0b expected 1", load_error); else pass_cnt++;
    send_cmd(2'd0, 32'd9, 32'd0, 32'd9, 16'd1, 8'h44);
    check_cnt++; if (load_error !== 1'b0) $display("[TB] FAIL arm_error_clear: got %0b expected 0", load_error); else pass_cnt++;
    pulse_stop();
  endtask

  task automatic test_reset_in_run();
    bit found;
    $display("[TB] reset during run");
    waveform_ready = 1'b1;
    send_cmd(2'd0, 32'h1234, 32'd0, 32'h1234, 16'd2, 8'h5A);
    capture_load(256, 1000);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      if (dds_enable === 1'b1) found = 1'b1;
    end
    check_cnt++; if (!found || frequency !== 32'h1234) $display("[TB] FAIL rrun_enable: got en=%0b freq=%0h expected 1 1234", found, frequency); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    check_cnt++; if (dds_enable !== 1'b0 || frequency !== 32'd0) $display("[TB] FAIL rrun_outputs: got en=%0b freq=%0h expected 0 0", dds_enable, frequency); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || amplitude !== 8'd0) $display("[TB] FAIL rrun_state: got busy=%0b ready=%0b amp=%0h expected 0 1 0", busy, cmd_ready, amplitude); else pass_cnt++;
    rst_n = 1'b0;
    waveform_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_wave_sel = 2'd0; cmd_freq_start = 32'd0;
    cmd_freq_step = 32'd0; cmd_freq_stop = 32'd0; cmd_dwell = 16'd0;
    cmd_amplitude = 8'd0; cmd_stop = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    waveform_ready = 1'b0;
    test_reset();
    test_saw();
    test_gen_modes();
    test_stream();
    test_sweep();
    test_stop_mid_load();
    test_arm_timeout();
    test_reset_in_run();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dac_wave_sequencer.md
Name: dac_wave_sequencer

Overview:
Controller that sequences the DDS DAC engine.
- On a command, it loads a 256-point waveform into the engine through the engine's edge-detected write-pulse interface. The waveform is either generated internally (saw/triangle/square) or streamed from an upstream source.
- It then programs amplitude and frequency, enables DDS output, and optionally runs a stepped frequency sweep until stopped.
- It sits between the register/command layer and the DAC engine.

Parameters:
WAVE_POINTS, 256, points per waveform load; must match the engine table depth.
PULSE_GAP, 1, low cycles inserted after each write pulse (>=1; the engine needs a low-to-high edge per point).
ARM_TIMEOUT, 15, cycles to wait for waveform_ready after the last point before flagging an error.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous, active-high reset (asserted when rst_n=1; sampled on rising clk only).
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE.
cmd_wave_sel  in  2  0=saw, 1=triangle, 2=square, 3=stream.
cmd_freq_start  in  32  initial phase increment.
cmd_freq_step  in  32  sweep increment; 0 = fixed tone.
cmd_freq_stop  in  32  sweep upper bound.
cmd_dwell  in  16  cycles per frequency step; 0 treated as 1.
cmd_amplitude  in  8  amplitude to engine.
cmd_stop  in  1  abort load / stop output.
s_valid  in  1  stream data valid (mode 3).
s_data  in  8  stream sample.
s_ready  out  1  stream accept.
dds_enable  out  1  to engine.
frequency  out  32  to engine.
amplitude  out  8  to engine.
wave_wr_pulse  out  1  to engine.
wave_data  out  8  to engine.
waveform_ready  in  1  from engine.
busy  out  1  state != IDLE.
sweep_done  out  1  one-cycle pulse per completed sweep.
load_error  out  1  sticky ARM timeout flag.

Behaviour:
- Reset values: state IDLE, cmd_ready=1, all other outputs 0, point index 0.
- States: IDLE -> LD_DATA -> LD_PULSE -> LD_GAP -> (LD_DATA | ARM) -> RUN -> IDLE.
- IDLE:
  - Command accepted on a clock edge with cmd_valid & cmd_ready.
  - All cmd_* fields are latched at accept. amplitude updates at the accept edge.
  - On accept: index=0, load_error cleared, dds_enable=0, go to LD_DATA.
- LD_DATA:
  - Generated modes: wave_data <= gen(index), then go to LD_PULSE next cycle.
    - Saw: gen(i)=i.
    - Triangle: i<128 ? 2i : 2(255-i), giving 0,2,...,254,254,...,2,0.
    - Square: i<128 ? 0xFF : 0x00.
  - Stream mode: s_ready=1 in LD_DATA only. Stay until s_valid; on s_valid & s_ready, wave_data <= s_data, then go to LD_PULSE.
- LD_PULSE: wave_wr_pulse=1 for exactly one cycle; wave_data stable.
- LD_GAP:
  - wave_wr_pulse=0 for PULSE_GAP cycles; wave_data held through the gap.
  - Then index++. If index was WAVE_POINTS-1, go to ARM; else go to LD_DATA.
- Load timing (generated mode, PULSE_GAP=1): 3 cycles/point, 768 cycles total.
- dds_enable stays 0 throughout the load.
- ARM:
  - When waveform_ready=1: frequency <= freq_start, dds_enable <= 1, dwell counter <= dwell, go to RUN.
  - If waveform_ready stays 0 for ARM_TIMEOUT cycles: load_error <= 1, go to IDLE.
- RUN:
  - Dwell counter decrements each cycle. At expiry:
    - If step==0: hold frequency; no sweep_done.
    - Else compute the 33-bit sum = frequency + step.
      - If sum <= stop: frequency <= sum.
      - Else: frequency <= freq_start and sweep_done pulses for 1 cycle.
    - Reload the dwell counter.
  - If start > stop with step != 0, frequency stays at start and sweep_done pulses every dwell.
- cmd_stop (priority over all other transitions in the same cycle):
  - In any LD_* or ARM state: go to IDLE next cycle, wave_wr_pulse=0, index reset. The engine table is left partially written.
  - In RUN: dds_enable=0 and go to IDLE next cycle; frequency/amplitude outputs hold their last values.
  - In IDLE: ignored.
- cmd_valid outside IDLE: ignored (cmd_ready=0).
- Reset mid-operation: reset values are restored on the next edge, regardless of state.

Test Plan:
- Reset then saw command (start=0x01000000, step=0, amplitude=0x80) -> exactly 256 write pulses, each followed by >=1 low cycle, carrying wave_data=0..255. dds_enable=0 during the load and rises after waveform_ready. frequency=0x01000000, amplitude=0x80.
- Triangle and square commands -> captured write data at i=0/127/128/255 equals 0/254/254/0 (triangle) and FF/FF/00/00 (square).
- Stream mode with s_valid toggling every other cycle, data 0xA5 xor i -> s_ready high only in LD_DATA. 256 pulses with the matching data; no sample dropped or duplicated.
- Sweep with start=100, step=50, stop=200, dwell=4 -> frequency sequence 100,150,200,100,... changing every 4 cycles, sweep_done pulsing at each return to 100. start=300 with stop=200 -> frequency fixed at 300, sweep_done every 4 cycles.
- cmd_stop at point 37 of a load -> next cycle IDLE, no further pulses, cmd_ready=1. A new command then restarts at index 0.
- waveform_ready tied 0 -> ARM times out after 15 cycles, load_error=1, dds_enable stays 0. load_error clears on the next accepted command. Reset asserted in RUN -> dds_enable=0 and frequency=0 after the next edge.
